// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter block.
//
// Contents:
//   DEF_CNT_W        default width of the high/period counters and results
//   DEF_SYNC_STAGES  default synchronizer depth on the measured input
//   ST_*             2-bit measurement FSM encodings
//   state_e          typed FSM state built on the ST_* encodings
//
// Optional feature macro used by the block: PULSE_METER_TIMEOUT_EN.

package pulse_meter_pkg;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StArmed = ST_ARMED,
        StHigh  = ST_HIGH,
        StLow   = ST_LOW
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with rising-edge detection.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops (must be 2 or more)
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous active-low reset; clears the chain and the delay flop
//   async_in  asynchronous input
//   level     synchronized level (last synchronizer stage)
//   rise      one-cycle pulse when level goes 0 -> 1

module sync_edge_detect
    import pulse_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q    <= '0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high width and period (in clock cycles) of an asynchronous pulse
// train and presents each completed measurement through a valid/ack handshake.
//
// Parameters:
//   CNT_W        counter / result width; counters saturate at 2^CNT_W-1
//   SYNC_STAGES  synchronizer depth on signal (2 or more)
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-low reset
//   signal      asynchronous pulse train under measurement
//   meas_ack    consumer accepts the pending result
//   meas_valid  a captured result is pending
//   high_cnt    high cycles of the last full period
//   period_cnt  cycles from one rising edge to the next
//   overflow    a counter saturated during the captured period
//   overrun     sticky; a result was dropped while one was pending
//   timeout     (PULSE_METER_TIMEOUT_EN only) one-cycle pulse when the period
//               counter saturates and the measurement is abandoned
//
// Macro PULSE_METER_TIMEOUT_EN: when defined, a saturated period counter in
// HIGH or LOW returns the FSM to IDLE without capture and pulses timeout.
// When undefined, the FSM keeps waiting and the next rise captures saturated
// values with overflow set.

module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    input  logic             meas_ack,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             overflow,
    output logic             overrun
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s;
    logic rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(signal),
        .level   (s),
        .rise    (rise)
    );

    // The synchronizer is flushed to 0 by reset, so s reads 0 for the first
    // SYNC_STAGES cycles regardless of signal. IDLE ignores s until the chain
    // holds a real sample, otherwise a signal already high at reset release
    // would look like a fresh rising edge.
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   primed;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign primed = fill_q[SYNC_STAGES-1];

    // Measurement FSM and counters
    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             sat_q, sat_d;
    logic             capture;
`ifdef PULSE_METER_TIMEOUT_EN
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        sat_d    = sat_q;
        capture  = 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (primed && !s) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (rise) begin
                    period_d = CNT_ONE;
                    high_d   = CNT_ONE;
                    sat_d    = 1'b0;
                    state_d  = StHigh;
                end
            end
            StHigh: begin
`ifdef PULSE_METER_TIMEOUT_EN
                if (period_q == CNT_MAX) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else
`endif
                begin
                    if (period_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        period_d = period_q + CNT_ONE;
                    end
                    if (s) begin
                        if (high_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            high_d = high_q + CNT_ONE;
                        end
                    end else begin
                        // The falling cycle counts toward the period only.
                        state_d = StLow;
                    end
                end
            end
            StLow: begin
                if (rise) begin
                    capture  = 1'b1;
                    period_d = CNT_ONE;
                    high_d   = CNT_ONE;
                    sat_d    = 1'b0;
                    state_d  = StHigh;
                end
`ifdef PULSE_METER_TIMEOUT_EN
                else if (period_q == CNT_MAX) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
`endif
                else if (period_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    period_d = period_q + CNT_ONE;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            period_q <= '0;
            high_q   <= '0;
            sat_q    <= 1'b0;
`ifdef PULSE_METER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
            sat_q    <= sat_d;
`ifdef PULSE_METER_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

`ifdef PULSE_METER_TIMEOUT_EN
    assign timeout = timeout_q;
`endif

    // Result registers and handshake
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             overflow_q, overflow_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        valid_d      = valid_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        overflow_d   = overflow_q;
        overrun_d    = overrun_q;

        if (valid_q && meas_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (capture) begin
            // A same-cycle ack frees the slot, so the new result replaces it.
            if (!valid_q || meas_ack) begin
                valid_d      = 1'b1;
                high_cnt_d   = high_q;
                period_cnt_d = period_q;
                overflow_d   = sat_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            overflow_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            overflow_q   <= overflow_d;
            overrun_q    <= overrun_d;
        end
    end

    assign meas_valid = valid_q;
    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign overflow   = overflow_q;
    assign overrun    = overrun_q;

endmodule
